// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard/forwarding logic.
//   FWD_*           : select codes for the EX operand forwarding muxes
//   stage_info_t    : per-stage destination tracking record
//   producer_hits() : true when a tracked stage produces the given source
package pipe_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Destination fields are stored at a fixed width; narrower register
  // specifiers are zero-extended into it.
  localparam int DEST_BITS = 8;

  typedef struct packed {
    logic                 valid;
    logic [DEST_BITS-1:0] dest;
    logic                 reg_write;
    logic                 mem_read;
  } stage_info_t;

  // $0 is hard-wired, so a write to it never produces a value to forward.
  function automatic logic producer_hits(input stage_info_t stg,
                                         input logic [DEST_BITS-1:0] src);
    return stg.valid && stg.reg_write && (stg.dest != '0) && (stg.dest == src);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source forwarding priority (pure combinational).
//   src, uses          : source specifier and whether it is actually read
//   ex_stage, mem_stage: shadow records of the instructions in EX and MEM
//   sel                : forwarding select for this source
//   ex_hit             : the EX-stage instruction produces this source
module fwd_select
  import pipe_pkg::*;
(
  input  logic [DEST_BITS-1:0] src,
  input  logic                 uses,
  input  stage_info_t          ex_stage,
  input  stage_info_t          mem_stage,
  output logic [1:0]           sel,
  output logic                 ex_hit
);

  logic mem_hit;

  assign ex_hit  = uses && producer_hits(ex_stage, src);
  assign mem_hit = uses && producer_hits(mem_stage, src);

  // Nearer producer wins.
  always_comb begin
    sel = FWD_REG;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use stall generation for the 5-stage pipeline.
//   clk, reset          : pipeline clock, synchronous active-high reset
//   id_*                : fields of the instruction currently leaving ID
//   flush               : taken branch this cycle, ID instruction squashed
//   forward_a/forward_b : registered EX operand mux selects (rs / rt)
//   stall               : combinational load-use hold for PC and IF/ID
//   stall_count         : saturating count of stall cycles
module hazard_forward_unit
  import pipe_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic [REG_BITS-1:0] id_dest,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                flush,
  output logic [1:0]          forward_a,
  output logic [1:0]          forward_b,
  output logic                stall,
  output logic [CNT_BITS-1:0] stall_count
);

  // Only EX and MEM are tracked: the register file resolves same-cycle
  // write/read itself, so a WB record would have no consumer here.
  stage_info_t ex_q, mem_q;

  logic [1:0] sel_a, sel_b;
  logic       ex_hit_a, ex_hit_b;
  logic       issue;

  fwd_select u_sel_rs (
    .src       (DEST_BITS'(id_rs)),
    .uses      (id_uses_rs),
    .ex_stage  (ex_q),
    .mem_stage (mem_q),
    .sel       (sel_a),
    .ex_hit    (ex_hit_a)
  );

  fwd_select u_sel_rt (
    .src       (DEST_BITS'(id_rt)),
    .uses      (id_uses_rt),
    .ex_stage  (ex_q),
    .mem_stage (mem_q),
    .sel       (sel_b),
    .ex_hit    (ex_hit_b)
  );

  // A load in EX cannot forward yet: hold the consumer one cycle so it
  // picks the value up from MEM/WB instead.
  assign stall = id_valid && !flush && ex_q.mem_read && (ex_hit_a || ex_hit_b);
  assign issue = id_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      forward_a <= FWD_REG;
      forward_b <= FWD_REG;
    end else begin
      mem_q           <= ex_q;
      ex_q.valid      <= issue;
      ex_q.dest       <= DEST_BITS'(id_dest);
      ex_q.reg_write  <= id_reg_write;
      ex_q.mem_read   <= id_mem_read;
      forward_a       <= issue ? sel_a : FWD_REG;
      forward_b       <= issue ? sel_b : FWD_REG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  localparam int RB = 5;
  localparam int CB = 2;  // narrow counter so saturation is reachable

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [RB-1:0] id_rs, id_rt, id_dest;
  logic          id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [1:0]    forward_a, forward_b;
  logic          stall;
  logic [CB-1:0] stall_count;

  hazard_forward_unit #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic          st;
    logic [CB-1:0] cnt;
    string         tag;
  } stall_exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] fa;
    logic [1:0] fb;
    string      tag;
  } fwd_exp_t;

  stall_exp_t stall_q[$];
  fwd_exp_t   fwd_q[$];

  int            cyc = 0;
  int            tests = 0;
  int            failed = 0;
  logic [CB-1:0] exp_cnt = '0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: outputs are checked mid-cycle against whatever the stimulus
  // side queued for this cycle.
  stall_exp_t se;
  fwd_exp_t   fe;
  always @(negedge clk) begin
    if (stall_q.size() > 0 && stall_q[0].cyc == cyc) begin
      se = stall_q.pop_front();
      tests++;
      if (stall !== se.st || stall_count !== se.cnt) begin
        failed++;
        $display("FAIL %s stall: got stall=%0b count=%0d, expected stall=%0b count=%0d",
                 se.tag, stall, stall_count, se.st, se.cnt);
      end
    end
    if (fwd_q.size() > 0 && fwd_q[0].cyc == cyc) begin
      fe = fwd_q.pop_front();
      tests++;
      if (forward_a !== fe.fa || forward_b !== fe.fb) begin
        failed++;
        $display("FAIL %s fwd: got a=%b b=%b, expected a=%b b=%b",
                 fe.tag, forward_a, forward_b, fe.fa, fe.fb);
      end
    end
  end

  // One ID slot per call. With rst=1 the slot is presented under reset and
  // nothing is expected from it.
  task automatic drive(input logic rst, input logic v, input int rs, input int rt,
                       input logic urs, input logic urt, input int dest,
                       input logic rw, input logic mr, input logic fl,
                       input logic est, input logic [1:0] efa, input logic [1:0] efb,
                       input string tag);
    @(posedge clk); #1;
    reset        = rst;
    id_valid     = v;
    id_rs        = RB'(rs);
    id_rt        = RB'(rt);
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_dest      = RB'(dest);
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
    if (rst) begin
      exp_cnt = '0;
    end else begin
      stall_q.push_back('{cyc, est, exp_cnt, tag});
      fwd_q.push_back('{cyc + 1, efa, efb, tag});
      if (est && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    end
  endtask

  task automatic idle(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, tag);
  endtask

  task automatic drain();
    idle("drain");
    idle("drain");
  endtask

  initial begin
    reset = 1'b1; id_valid = 0; id_rs = '0; id_rt = '0; id_uses_rs = 0;
    id_uses_rt = 0; id_dest = '0; id_reg_write = 0; id_mem_read = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    idle("after_reset");
    idle("after_reset2");

    // ADD $3 then SUB reading $3 as rs
    drive(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, "add3");
    drive(0, 1, 3, 7, 1, 1, 8, 1, 0, 0, 0, 2'b10, 2'b00, "sub_rs3");
    drain();

    // ADD $3, unrelated, OR reading $3 as rt
    drive(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, "add3b");
    drive(0, 1, 9, 10, 1, 1, 11, 1, 0, 0, 0, 2'b00, 2'b00, "unrelated");
    drive(0, 1, 12, 3, 1, 1, 13, 1, 0, 0, 0, 2'b00, 2'b01, "or_rt3");
    drain();

    // Two writers of $4, then reader on both sources
    drive(0, 1, 1, 2, 1, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00, "w4a");
    drive(0, 1, 5, 6, 1, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00, "w4b");
    drive(0, 1, 4, 4, 1, 1, 14, 1, 0, 0, 0, 2'b10, 2'b10, "r4_nearest");
    drain();

    // LW $5, ADD reading $5: one stall, then forward from WB
    drive(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, "lw5");
    drive(0, 1, 5, 6, 1, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, "add5_stall");
    drive(0, 1, 5, 6, 1, 1, 10, 1, 0, 0, 0, 2'b01, 2'b00, "add5_retry");
    drain();

    // Writer of $0, reader of $0
    drive(0, 1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, "w0");
    drive(0, 1, 0, 0, 1, 1, 15, 1, 0, 0, 0, 2'b00, 2'b00, "r0");
    drain();

    // Matching source that is not actually read
    drive(0, 1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, "w9");
    drive(0, 1, 9, 2, 0, 1, 16, 1, 0, 0, 0, 2'b00, 2'b00, "r9_unused");
    drain();

    // Load-use with flush: no stall, count unchanged
    drive(0, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, "lw7");
    drive(0, 1, 7, 2, 1, 1, 17, 1, 0, 1, 0, 2'b00, 2'b00, "add7_flush");
    drain();

    // Load presented under reset must be forgotten
    drive(1, 1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00, "lw8_rst");
    drive(0, 1, 8, 2, 1, 1, 18, 1, 0, 0, 0, 2'b00, 2'b00, "add8_post_rst");
    drain();

    // Counter saturation: four load-use pairs into a 2-bit counter
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, "sat_lw");
      drive(0, 1, 2, 5, 1, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, "sat_stall");
      drive(0, 1, 2, 5, 1, 1, 10, 1, 0, 0, 0, 2'b00, 2'b01, "sat_retry");
      drain();
    end
    idle("sat_final");

    repeat (3) @(posedge clk);
    tests++;
    if (stall_q.size() != 0 || fwd_q.size() != 0) begin
      failed++;
      $display("FAIL queues_drained: got %0d/%0d pending, expected 0/0",
               stall_q.size(), fwd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
